// File: rtl/romulusn_ctrl_pkg.sv
// Shared types and helpers for the Romulus-N sequencer.
// Optional abort input is enabled with ROMULUS_ABORT_EN (see romulusn_ctrl.sv).
package romulusn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_RESTORE,
    S_UNLOAD,
    S_DONE
  } state_t;

  localparam logic [5:0] RC_INIT    = 6'h00;
  localparam int         DEF_ROUNDS = 40;
  localparam int         DEF_WORDS  = 4;

  // One step of the SKINNY 6-bit round-constant LFSR
  function automatic logic [5:0] rc_step(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/romulusn_ctrl_if.sv
// pdi/sdi/pdo beat handshakes between the LWC front end and the sequencer.
// master = data source/sink side, slave = sequencer side.
interface romulusn_ctrl_if;
  logic pdi_valid;
  logic pdi_ready;
  logic sdi_valid;
  logic sdi_ready;
  logic pdo_valid;
  logic pdo_ready;

  modport master (output pdi_valid, sdi_valid, pdo_ready,
                  input  pdi_ready, sdi_ready, pdo_valid);
  modport slave  (input  pdi_valid, sdi_valid, pdo_ready,
                  output pdi_ready, sdi_ready, pdo_valid);
endinterface

// File: rtl/romulusn_ctrl_rc4.sv
// Round-constant LFSR producing four consecutive constants per cycle
// for the 4-round/cycle datapath.
module skinny_rc4
  import romulusn_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_adv,
  output logic [5:0] o_c1,
  output logic [5:0] o_c2,
  output logic [5:0] o_c3,
  output logic [5:0] o_c4
);

  logic [5:0] r_rc;

  assign o_c1 = rc_step(r_rc);
  assign o_c2 = rc_step(o_c1);
  assign o_c3 = rc_step(o_c2);
  assign o_c4 = rc_step(o_c3);

  // LFSR state: cleared per block, jumps four steps per round cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_rc <= RC_INIT;
    else if (i_clr) r_rc <= RC_INIT;
    else if (i_adv) r_rc <= o_c4;
  end

endmodule

// File: rtl/romulusn_ctrl.sv
// Romulus-N datapath sequencer: LOAD -> ROUND -> RESTORE -> UNLOAD -> DONE.
// Optional feature: define ROMULUS_ABORT_EN to add an abort input that
// drops any in-flight op back to IDLE without a done pulse.
module romulusn_ctrl
  import romulusn_ctrl_pkg::*;
#(
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int WORDS  = DEF_WORDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op_key,
  input  logic       op_ad,
  input  logic [7:0] dom_in,
  input  logic       dec_in,
  input  logic [3:0] last_bytes,
`ifdef ROMULUS_ABORT_EN
  input  logic       abort,
`endif
  romulusn_ctrl_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic       srst,
  output logic       senc,
  output logic       sse,
  output logic       xrst,
  output logic       xenc,
  output logic       xse,
  output logic       yrst,
  output logic       yenc,
  output logic       yse,
  output logic       zrst,
  output logic       zenc,
  output logic       zse,
  output logic       erst,
  output logic       correct_cnt,
  output logic       tk1s,
  output logic [5:0] constant,
  output logic [5:0] constant2,
  output logic [5:0] constant3,
  output logic [5:0] constant4,
  output logic [7:0] domain,
  output logic [3:0] decrypt
);

  localparam int NCYC = ROUNDS / 4;
  localparam int RW   = (NCYC  > 1) ? $clog2(NCYC)  : 1;
  localparam int BW   = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t          r_state, w_nxt;
  logic [BW-1:0]   r_beat;
  logic [RW-1:0]   r_rnd;
  logic            r_key, r_ad, r_dec;
  logic [7:0]      r_dom;

  logic            w_abort, w_ld_go, w_ul_go, w_beat_last, w_rnd_last;
  logic            w_beat_inc, w_rc_clr, w_rc_adv;
  logic [5:0]      w_c1, w_c2, w_c3, w_c4;

`ifdef ROMULUS_ABORT_EN
  assign w_abort = abort & (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // A key beat needs both words at once; neither side is consumed alone
  assign w_ld_go     = bus.pdi_valid & (bus.sdi_valid | ~r_key);
  assign w_ul_go     = r_ad | bus.pdo_ready;
  assign w_beat_last = (r_beat == BW'(WORDS - 1));
  assign w_rnd_last  = (r_rnd  == RW'(NCYC - 1));
  assign domain      = r_dom;

  skinny_rc4 u_rc (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_rc_clr),
    .i_adv (w_rc_adv),
    .o_c1  (w_c1),
    .o_c2  (w_c2),
    .o_c3  (w_c3),
    .o_c4  (w_c4)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // Per-op attributes captured at start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key <= 1'b0;
      r_ad  <= 1'b0;
      r_dec <= 1'b0;
      r_dom <= 8'h00;
    end else if (r_state == S_IDLE && start) begin
      r_key <= op_key;
      r_ad  <= op_ad;
      r_dec <= dec_in;
      r_dom <= dom_in;
    end
  end

  // Beat and round counters; both wrap to 0 on their last step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat <= '0;
      r_rnd  <= '0;
    end else if (w_abort) begin
      r_beat <= '0;
      r_rnd  <= '0;
    end else begin
      if (w_beat_inc) r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
      if (w_rc_adv)   r_rnd  <= w_rnd_last  ? '0 : r_rnd  + 1'b1;
    end
  end

  // Next state and all datapath controls
  always_comb begin
    w_nxt         = r_state;
    w_beat_inc    = 1'b0;
    w_rc_clr      = 1'b0;
    w_rc_adv      = 1'b0;
    busy          = (r_state != S_IDLE);
    done          = 1'b0;
    srst          = 1'b0;
    senc          = 1'b0;
    sse           = 1'b0;
    xrst          = 1'b0;
    xenc          = 1'b0;
    xse           = 1'b0;
    yrst          = 1'b0;
    yenc          = 1'b0;
    yse           = 1'b0;
    zrst          = 1'b0;
    zenc          = 1'b0;
    zse           = 1'b0;
    erst          = 1'b0;
    correct_cnt   = 1'b0;
    tk1s          = 1'b0;
    constant      = 6'h00;
    constant2     = 6'h00;
    constant3     = 6'h00;
    constant4     = 6'h00;
    decrypt       = 4'h0;
    bus.pdi_ready = 1'b0;
    bus.sdi_ready = 1'b0;
    bus.pdo_valid = 1'b0;
    if (w_abort) begin
      w_nxt    = S_IDLE;
      w_rc_clr = 1'b1;
    end else begin
      tk1s = r_ad & (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_nxt    = S_LOAD;
            w_rc_clr = 1'b1;
          end
        end
        S_LOAD: begin
          bus.pdi_ready = ~r_key | bus.sdi_valid;
          bus.sdi_ready = r_key & bus.pdi_valid;
          decrypt       = {4{r_dec}} & (w_beat_last ? last_bytes : 4'hF);
          if (w_ld_go) begin
            senc       = 1'b1;
            sse        = 1'b1;
            xenc       = r_key;
            xse        = r_key;
            w_beat_inc = 1'b1;
            if (w_beat_last) w_nxt = S_ROUND;
          end
        end
        S_ROUND: begin
          senc      = 1'b1;
          xenc      = 1'b1;
          yenc      = 1'b1;
          zenc      = 1'b1;
          constant  = w_c1;
          constant2 = w_c2;
          constant3 = w_c3;
          constant4 = w_c4;
          w_rc_adv  = 1'b1;
          if (w_rnd_last) w_nxt = S_RESTORE;
        end
        S_RESTORE: begin
          xrst        = 1'b1;
          yrst        = 1'b1;
          zrst        = 1'b1;
          xenc        = 1'b1;
          yenc        = 1'b1;
          zenc        = 1'b1;
          correct_cnt = 1'b1;
          erst        = 1'b1;
          w_nxt       = S_UNLOAD;
        end
        S_UNLOAD: begin
          bus.pdo_valid = ~r_ad;
          if (w_ul_go) begin
            senc       = 1'b1;
            sse        = 1'b1;
            w_beat_inc = 1'b1;
            if (w_beat_last) w_nxt = S_DONE;
          end
        end
        S_DONE: begin
          done  = 1'b1;
          w_nxt = S_IDLE;
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

endmodule
